// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC-driven instruction fetch into a small prefetch FIFO with redirect and halt
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    output logic [31:0]                     imem_addr,
    input  logic [31:0]                     imem_dout,
    input  logic                            redirect_valid,
    input  logic [31:0]                     redirect_target,
    input  logic                            halt,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [31:0]                     out_inst,
    output logic [31:0]                     out_pc,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    logic [31:0]   pc;
    logic [31:0]   ent_pc   [FIFO_DEPTH];
    logic [31:0]   ent_inst [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          deq, fetch;
    assign imem_addr  = pc;
    assign fifo_count = count;
    assign out_valid  = count != '0;
    assign out_inst   = out_valid ? ent_inst[rd_ptr] : '0;
    assign out_pc     = out_valid ? ent_pc[rd_ptr] : '0;
    assign deq        = out_valid & out_ready & ~redirect_valid;
    // a full FIFO may still accept a fetch when its head leaves on the same edge
    assign fetch      = ~redirect_valid & ~halt & ((count < CW'(FIFO_DEPTH)) | deq);
    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            pc     <= redirect_target & ~32'h3;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (fetch) begin
                ent_pc[wr_ptr]   <= pc;
                ent_inst[wr_ptr] <= imem_dout;
                wr_ptr           <= wr_ptr + 1'b1;
                pc               <= pc + 32'd4;
            end
            if (deq)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(fetch) - CW'(deq);
        end
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed vector table plus a randomized program-order run
module tb_inst_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_addr, imem_dout;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        halt = 1'b0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_inst, out_pc;
    logic [1:0]  fifo_count;
    logic [31:0] mem [256];
    int          n_chk = 0;
    int          n_fail = 0;

    inst_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_dout(imem_dout),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target), .halt(halt),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;
    assign imem_dout = mem[imem_addr[9:2]];

    typedef struct {
        logic        rst, rv;
        logic [31:0] tgt;
        logic        hlt, rdy, chk, v;
        logic [31:0] pc, inst;
        int          cnt;
        logic [31:0] addr;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic rst, rv, input logic [31:0] tgt, input logic hlt, rdy, chk, v,
                       input logic [31:0] pc, inst, input int cnt, input logic [31:0] addr);
        vec_t e;
        e.rst = rst; e.rv = rv; e.tgt = tgt; e.hlt = hlt; e.rdy = rdy; e.chk = chk; e.v = v;
        e.pc = pc; e.inst = inst; e.cnt = cnt; e.addr = addr;
        tbl.push_back(e);
    endtask

    task automatic check(input string name, input int row, input logic [31:0] act, exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    initial begin
        logic [31:0] exp_pc;
        for (int i = 0; i < 256; i++) mem[i] = 32'h11 * (i + 1);
        // row: rst rv tgt hlt rdy chk | valid pc inst count addr  (outputs seen before the row's edge)
        add(1,0,0,0,1,0, 0,0,0,0,0);
        add(0,0,0,0,1,1, 0,32'h0,32'h0,0,32'h0);
        add(0,0,0,0,1,1, 1,32'h0,32'h11,1,32'h4);
        add(0,0,0,0,1,1, 1,32'h4,32'h22,1,32'h8);
        add(0,0,0,0,1,1, 1,32'h8,32'h33,1,32'hC);
        add(1,0,0,0,1,1, 1,32'hC,32'h44,1,32'h10);
        add(0,0,0,0,0,1, 0,32'h0,32'h0,0,32'h0);
        add(0,0,0,0,0,1, 1,32'h0,32'h11,1,32'h4);
        add(0,0,0,0,0,1, 1,32'h0,32'h11,2,32'h8);
        add(0,0,0,0,0,1, 1,32'h0,32'h11,2,32'h8);
        add(0,0,0,0,1,1, 1,32'h0,32'h11,2,32'h8);
        add(0,1,32'h103,0,1,1, 1,32'h4,32'h22,2,32'hC);
        add(0,0,0,0,1,1, 0,32'h0,32'h0,0,32'h100);
        add(0,0,0,0,1,1, 1,32'h100,32'h451,1,32'h104);
        add(0,1,32'h8,0,0,1, 1,32'h104,32'h462,1,32'h108);
        add(0,0,0,0,0,1, 0,32'h0,32'h0,0,32'h8);
        add(0,0,0,0,0,1, 1,32'h8,32'h33,1,32'hC);
        add(0,0,0,1,1,1, 1,32'h8,32'h33,2,32'h10);
        add(0,0,0,1,1,1, 1,32'hC,32'h44,1,32'h10);
        add(0,0,0,1,1,1, 0,32'h0,32'h0,0,32'h10);
        add(0,0,0,0,1,1, 0,32'h0,32'h0,0,32'h10);
        add(0,0,0,0,1,1, 1,32'h10,32'h55,1,32'h14);
        add(0,0,0,0,0,1, 1,32'h14,32'h66,1,32'h18);
        add(0,0,0,0,0,1, 1,32'h14,32'h66,2,32'h1C);
        add(0,0,0,0,1,1, 1,32'h14,32'h66,2,32'h1C);
        add(1,0,0,0,1,1, 1,32'h18,32'h77,2,32'h20);
        add(0,0,0,0,1,1, 0,32'h0,32'h0,0,32'h0);
        add(0,1,32'h40,1,1,1, 1,32'h0,32'h11,1,32'h4);
        add(0,0,0,1,1,1, 0,32'h0,32'h0,0,32'h40);
        add(0,0,0,0,1,1, 0,32'h0,32'h0,0,32'h40);
        add(0,1,32'hFFFF_FFFF,0,1,1, 1,32'h40,32'h121,1,32'h44);
        add(0,0,0,0,1,1, 0,32'h0,32'h0,0,32'hFFFF_FFFC);
        add(0,0,0,0,1,1, 1,32'hFFFF_FFFC,32'h1100,1,32'h0);
        add(0,0,0,0,1,1, 1,32'h0,32'h11,1,32'h4);
        for (int r = 0; r < tbl.size(); r++) begin
            @(negedge clk);
            reset = tbl[r].rst; redirect_valid = tbl[r].rv; redirect_target = tbl[r].tgt;
            halt = tbl[r].hlt; out_ready = tbl[r].rdy;
            if (tbl[r].chk) begin
                check("out_valid", r, 32'(out_valid), 32'(tbl[r].v));
                check("out_pc", r, out_pc, tbl[r].pc);
                check("out_inst", r, out_inst, tbl[r].inst);
                check("fifo_count", r, 32'(fifo_count), tbl[r].cnt);
                check("imem_addr", r, imem_addr, tbl[r].addr);
            end
        end
        // random ready/halt stream: every delivered entry must be next in program order
        @(negedge clk);
        reset = 1'b1; redirect_valid = 1'b0; halt = 1'b0; out_ready = 1'b0;
        exp_pc = 32'h0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            reset = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            halt = ($urandom_range(0, 3) == 0);
            check("count_bound", c, 32'(fifo_count <= 2'd2), 32'd1);
            if (out_valid && out_ready) begin
                check("stream_pc", c, out_pc, exp_pc);
                check("stream_inst", c, out_inst, mem[exp_pc[9:2]]);
                exp_pc = exp_pc + 32'd4;
            end
        end
        check("stream_progress", 0, 32'(exp_pc > 32'd40), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
